nanov_sequencer: RTL and testbench

- Control sequencer for the bit-serial nanoV core.
- Fetches 32-bit instructions over a valid/req handshake and presents them to the core.
- Generates the core's counter (bit index 0..31) and cycle (pass index) timebase, and holds the program counter.
- Serialises store data out of the core's data_out buffer and applies jump/branch targets.

---
 rtl/nanov_sequencer_if.sv | 21 ++
 rtl/nanov_sequencer.sv | 154 +++++++++++++++
 tb/tb_nanov_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/nanov_sequencer_if.sv
// Fetch and store-serialisation bus between the nanoV sequencer (master)
// and the instruction memory / store sink (slave).
interface nanov_sequencer_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic        store_valid;
  logic        store_data;
  logic        store_ready;

  modport master (
    output instr_req, instr_addr, store_valid, store_data,
    input  instr_valid, instr_data, store_ready
  );

  modport slave (
    input  instr_req, instr_addr, store_valid, store_data,
    output instr_valid, instr_data, store_ready
  );
endinterface

// File: rtl/nanov_sequencer.sv
// Control sequencer for the bit-serial nanoV core: fetch, 32/64-clk exec timebase,
// MSB-first store serialisation and PC update. Define NANOV_SEQ_RETIRE_EN for the retired counter.
module nanov_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  nanov_sequencer_if.master bus,
  output logic [31:0]       instr,
  output logic [2:0]        cycle,
  output logic [4:0]        counter,
  output logic              pc,
  input  logic              branch,
  input  logic [31:0]       data_out,
  output logic              shift_data_out,
  output logic              busy
`ifdef NANOV_SEQ_RETIRE_EN
  ,
  output logic [31:0]       retired
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    STORE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [4:0]  counter_reg, counter_next;
  logic [2:0]  cycle_reg, cycle_next;
  logic        taken_reg, taken_next;
  logic        pc_update;

  logic [6:0]  opcode;
  logic [1:0]  funct3_lo;
  logic        is_two_pass;
  logic        is_store;
  logic        pass_done;
  logic        last_pass;
  logic        taken_now;
  logic [31:0] pc_target;

  assign opcode    = instr_reg[6:0];
  assign funct3_lo = instr_reg[13:12];

  // Jumps, branches and shifts need a second pass over the operand bits.
  assign is_two_pass = ((opcode[6:4] == 3'b110) && opcode[2])
                     || (opcode[6:2] == 5'b11000)
                     || (opcode[4] && (funct3_lo == 2'b01));
  assign is_store    = (opcode[6:2] == 5'b01000);
  assign pass_done   = (counter_reg == 5'd31);
  assign last_pass   = (cycle_reg == {2'b00, is_two_pass});

  // A branch strobe on the final exec clock still counts towards the target.
  assign taken_now = taken_reg || ((state_reg == EXEC) && branch);
  assign pc_target = taken_now ? (data_out & 32'hFFFF_FFFE) : (pc_reg + 32'd4);

`ifdef NANOV_SEQ_RETIRE_EN
  logic [31:0] retired_reg, retired_next;
  assign retired_next = retired_reg + {31'd0, pc_update};
  assign retired      = retired_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= FETCH;
      pc_reg      <= RESET_PC & 32'hFFFF_FFFC;
      instr_reg   <= NOP_INSTR;
      counter_reg <= 5'd0;
      cycle_reg   <= 3'd0;
      taken_reg   <= 1'b0;
`ifdef NANOV_SEQ_RETIRE_EN
      retired_reg <= 32'd0;
`endif
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      instr_reg   <= instr_next;
      counter_reg <= counter_next;
      cycle_reg   <= cycle_next;
      taken_reg   <= taken_next;
`ifdef NANOV_SEQ_RETIRE_EN
      retired_reg <= retired_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    instr_next   = instr_reg;
    counter_next = counter_reg;
    cycle_next   = cycle_reg;
    taken_next   = taken_reg;
    pc_update    = 1'b0;
    case (state_reg)
      FETCH: begin
        counter_next = 5'd0;
        cycle_next   = 3'd0;
        if (bus.instr_valid) begin
          instr_next = bus.instr_data;
          taken_next = 1'b0;
          state_next = EXEC;
        end
      end
      EXEC: begin
        taken_next   = taken_now;
        counter_next = counter_reg + 5'd1;
        if (pass_done) begin
          if (last_pass) begin
            cycle_next = 3'd0;
            if (is_store) begin
              state_next = STORE;
            end else begin
              pc_update  = 1'b1;
              state_next = FETCH;
            end
          end else begin
            cycle_next = cycle_reg + 3'd1;
          end
        end
      end
      STORE: begin
        if (bus.store_ready) begin
          counter_next = counter_reg + 5'd1;
          if (pass_done) begin
            pc_update  = 1'b1;
            state_next = FETCH;
          end
        end
      end
      default: state_next = FETCH;
    endcase
    if (pc_update) pc_next = pc_target;
  end

  always_comb begin
    bus.instr_req   = (state_reg == FETCH);
    bus.instr_addr  = pc_reg;
    bus.store_valid = (state_reg == STORE);
    bus.store_data  = data_out[31];
    shift_data_out  = (state_reg == STORE) && bus.store_ready;
    instr           = (state_reg == EXEC) ? instr_reg : NOP_INSTR;
    cycle           = cycle_reg;
    counter         = counter_reg;
    pc              = pc_reg[counter_reg];
    busy            = (state_reg != FETCH);
  end

endmodule

// File: tb/tb_nanov_sequencer.sv
// Randomised bench for nanov_sequencer against an instruction-level reference model
// (instruction length, serial PC, store bit order, next PC, retired count).
module tb_nanov_sequencer;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [2:0]  cycle;
  logic [4:0]  counter;
  logic        pc;
  logic        branch;
  logic [31:0] data_out;
  logic        shift_data_out;
  logic        busy;
`ifdef NANOV_SEQ_RETIRE_EN
  logic [31:0] retired;
`endif

  nanov_sequencer_if bus ();

  nanov_sequencer #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .instr          (instr),
    .cycle          (cycle),
    .counter        (counter),
    .pc             (pc),
    .branch         (branch),
    .data_out       (data_out),
    .shift_data_out (shift_data_out),
    .busy           (busy)
`ifdef NANOV_SEQ_RETIRE_EN
    ,
    .retired        (retired)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_retired;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Pass count from the instruction-class rules.
  function automatic int spec_len(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] f3;
    bit two;
    op  = i[6:0];
    f3  = i[14:12];
    two = (op[6:4] == 3'b110 && op[2] == 1'b1) || (op[6:2] == 5'b11000)
        || (op[4] == 1'b1 && f3[1:0] == 2'b01);
    return two ? 64 : 32;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_req"}, bus.instr_req, 1);
    check({tag, "_addr"}, bus.instr_addr, m_pc);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sv"}, bus.store_valid, 0);
    check({tag, "_shift"}, shift_data_out, 0);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_timebase"}, {24'd0, cycle, counter}, 0);
`ifdef NANOV_SEQ_RETIRE_EN
    check({tag, "_retired"}, retired, m_retired);
`endif
  endtask

  // Reset lands together with a fetch handshake; the handshake must be dropped.
  task automatic do_abort();
    rst = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr_data  = 32'h0000_0063;
    @(negedge clk);
    rst = 1'b0;
    bus.instr_valid = 1'b0;
    m_pc      = RST_PC & 32'hFFFF_FFFC;
    m_retired = 32'd0;
    #1;
    check_idle("abort");
    $display("txn abort -> pc %h", m_pc);
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic [31:0] dval, input int br_at,
                           input int br_pct, input int wait_n, input bit ready_toggle,
                           input int abort_at);
    int          len;
    bit          tk;
    bit          is_st;
    logic [31:0] d;
    logic [31:0] last_d;
    int          acc;
    int          tries;
    len   = spec_len(ins);
    is_st = (ins[6:2] == 5'b01000);
    for (int w = 0; w <= wait_n; w++) begin
      @(negedge clk);
      branch          = 1'($urandom_range(0, 1));
      data_out        = $urandom;
      bus.store_ready = 1'($urandom_range(0, 1));
      bus.instr_valid = (w == wait_n);
      bus.instr_data  = (w == wait_n) ? ins : $urandom;
      #1;
      check_idle("fetch");
    end
    tk = 1'b0;
    d  = dval;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      bus.instr_valid = 1'($urandom_range(0, 1));
      bus.instr_data  = $urandom;
      branch   = (k == br_at) || ($urandom_range(0, 99) < br_pct);
      data_out = d;
      #1;
      check("exec_instr", instr, ins);
      check("exec_cycle", cycle, k / 32);
      check("exec_counter", counter, k % 32);
      check("exec_pc_bit", pc, m_pc[k % 32]);
      check("exec_busy", busy, 1);
      check("exec_req", bus.instr_req, 0);
      check("exec_sv", bus.store_valid, 0);
      if (k == abort_at) begin
        do_abort();
        return;
      end
      if (branch) tk = 1'b1;
    end
    last_d = d;
    if (is_st) begin
      acc   = 0;
      tries = 0;
      while (acc < 32 && tries < 500) begin
        @(negedge clk);
        branch          = 1'($urandom_range(0, 1));
        bus.instr_valid = 1'($urandom_range(0, 1));
        data_out        = d;
        bus.store_ready = ready_toggle ? (tries % 2 == 0) : ($urandom_range(0, 2) != 0);
        #1;
        check("st_valid", bus.store_valid, 1);
        check("st_data", bus.store_data, dval[31 - acc]);
        check("st_shift", shift_data_out, bus.store_ready);
        check("st_instr", instr, NOP);
        check("st_cycle", cycle, 0);
        check("st_counter", counter, acc);
        if (tries == abort_at - len) begin
          do_abort();
          return;
        end
        if (bus.store_ready) begin
          acc++;
          last_d = d;
          d = {d[30:0], d[31]};
        end
        tries++;
      end
      if (acc < 32) check("st_timeout", acc, 32);
    end
    m_pc      = tk ? {last_d[31:1], 1'b0} : m_pc + 32'd4;
    m_retired = m_retired + 32'd1;
    $display("txn instr %h len %0d store %0d taken %0d -> pc %h", ins, len, is_st, tk, m_pc);
  endtask

  logic [6:0]  ops [8] = '{7'h13, 7'h33, 7'h63, 7'h6F, 7'h67, 7'h23, 7'h03, 7'h37};
  logic [31:0] r;
  logic [31:0] rins;

  initial begin
    rst = 1'b1;
    branch = 1'b0;
    data_out = 32'd0;
    bus.instr_valid = 1'b0;
    bus.instr_data  = 32'd0;
    bus.store_ready = 1'b0;
    m_pc      = RST_PC & 32'hFFFF_FFFC;
    m_retired = 32'd0;
    repeat (2) @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_data  = 32'h0000_006F;
    @(negedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    bus.instr_valid = 1'b0;

    // Directed: wrap from 0xFFFFFFFC, branch target, jal taken/not-taken, toggled-ready store.
    run_instr(32'h0000_0013, 32'h0000_0000, -1, 0, 0, 1'b0, -1);
    run_instr(32'h0000_0063, 32'h0000_0101, 31, 0, 1, 1'b0, -1);
    run_instr(32'h0000_006F, 32'h0000_0040,  0, 0, 0, 1'b0, -1);
    run_instr(32'h0000_006F, 32'h0000_0040, -1, 0, 2, 1'b0, -1);
    run_instr(32'h0000_2023, 32'hA5A5_0001, -1, 0, 0, 1'b1, -1);

    for (int n = 0; n < 40; n++) begin
      r    = $urandom;
      rins = (n % 8 == 7) ? r : {r[31:7], ops[$urandom_range(0, 7)]};
      run_instr(rins, $urandom, -1, 3, $urandom_range(0, 3), 1'b0, -1);
    end

    // Aborts: mid-exec at counter 17, then mid-store.
    run_instr(32'h0000_0033, $urandom, -1, 3, 0, 1'b0, 17);
    run_instr(32'h0000_0013, $urandom, -1, 0, 0, 1'b0, -1);
    run_instr(32'h0000_2023, 32'h1234_5678, -1, 0, 0, 1'b0, 32 + 10);
    run_instr(32'h0000_2023, 32'h8000_0001, 5, 0, 1, 1'b0, -1);
    run_instr(32'h0000_0013, $urandom, -1, 0, 0, 1'b0, -1);

    @(negedge clk);
    #1;
    check_idle("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
